// File: rtl/demux14_pkg.sv
// demux14_pkg
// Shared constants and types for the 1-to-4 stream demultiplexer.
//   NCH          - number of output channels
//   SELW         - width of the channel select
//   chan_state_t - per-channel buffer state (EMPTY / FULL)
package demux14_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/demux14_chan.sv
// demux14_chan
// One output channel of the demultiplexer: a one-entry buffer, its
// EMPTY/FULL state machine and a wrapping delivered-beat counter.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load       - the upstream beat is accepted into this channel this cycle
//   load_data  - payload to capture on load
//   valid      - buffer holds a beat (state FULL)
//   ready      - downstream consumer ready
//   data       - buffered payload
//   count      - number of beats delivered, modulo 2^CW
module demux14_chan
    import demux14_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic [CW-1:0] count
);

    chan_state_t state;
    chan_state_t state_next;
    logic        deliver;

    assign deliver = valid & ready;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A load always leaves the channel FULL, even when the
    // current beat is being delivered in the same cycle (pass-through).
    always_comb begin
        // NOTE: assigning a default first keeps this block from inferring a
        // latch when no case arm writes state_next.
        state_next = state;
        unique case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (deliver && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output logic.
    always_comb begin
        valid = (state == FULL);
    end

    // Payload register only changes on load; the top only loads a FULL
    // channel when it is also delivering, so the data is held while stalled.
    always_ff @(posedge clk) begin
        // NOTE: the payload is a single register, not a memory array, so it
        // is cleared on reset to give a defined out_data after reset.
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (deliver) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/demux14_stream.sv
// demux14_stream
// 1-to-4 valid/ready stream demultiplexer with one-entry buffer and a
// delivered-beat counter per channel. Beats are steered by in_sel and
// appear on the selected channel one cycle after acceptance.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - upstream beat valid
//   in_ready   - upstream beat accepted this cycle (depends on in_sel only)
//   in_data    - upstream payload, DW bits
//   in_sel     - destination channel 0..3
//   out_valid  - per-channel valid, bit k = channel k
//   out_ready  - per-channel consumer ready, bit k = channel k
//   out_data   - per-channel payload, channel k at [k*DW +: DW]
//   ch_count   - per-channel delivered count, channel k at [k*CW +: CW]
module demux14_stream
    import demux14_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [SELW-1:0]   in_sel,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [NCH*DW-1:0] out_data,
    output logic [NCH*CW-1:0] ch_count
);

    logic [NCH-1:0] load;

    // The addressed channel can take a beat if it is empty or draining this
    // cycle; other channels never influence in_ready.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    always_comb begin
        load         = '0;
        load[in_sel] = in_valid & in_ready;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux14_chan #(
            .DW (DW),
            .CW (CW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .valid     (out_valid[k]),
            .ready     (out_ready[k]),
            .data      (out_data[k*DW +: DW]),
            .count     (ch_count[k*CW +: CW])
        );
    end

endmodule

// File: doc/demux14_stream.md
DEMUX14_STREAM -- requirements
Module: demux14_stream

Interface
REQ-001 Parameter DW, default 8, SHALL set the data width of every beat.
REQ-002 Parameter CW, default 8, SHALL set the width of each per-channel delivered-beat counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that the upstream beat is valid.
REQ-006 in_ready  output  1  SHALL indicate that the block accepts the upstream beat this cycle.
REQ-007 in_data  input  DW  SHALL carry the upstream beat payload.
REQ-008 in_sel  input  2  SHALL select the destination channel (0..3) of the upstream beat.
REQ-009 out_valid  output  4  SHALL carry the per-channel valid flag; bit k belongs to channel k.
REQ-010 out_ready  input  4  SHALL carry the per-channel consumer ready; bit k belongs to channel k.
REQ-011 out_data  output  4*DW  SHALL carry the per-channel payload; channel k occupies bits [k*DW +: DW].
REQ-012 ch_count  output  4*CW  SHALL carry the per-channel delivered-beat count; channel k occupies bits [k*CW +: CW].

Function
REQ-013 Each channel SHALL hold a one-entry buffer with a 2-state FSM: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 in_ready SHALL equal (~out_valid[in_sel]) | out_ready[in_sel], combinationally; it is independent of in_valid.
REQ-015 Upstream accept SHALL occur when in_valid & in_ready; on accept, channel in_sel loads in_data and is FULL next cycle.
REQ-016 Channel delivery SHALL occur when out_valid[k] & out_ready[k]; on delivery without a simultaneous load, channel k goes to EMPTY next cycle.
REQ-017 Simultaneous delivery and load on the same channel SHALL leave it FULL with the new data; no beat is lost or duplicated.
REQ-018 Input-to-output latency SHALL be exactly 1 cycle: a beat accepted in cycle n is presented on out_data[in_sel] in cycle n+1.
REQ-019 out_data[k] SHALL remain stable while out_valid[k]=1 and out_ready[k]=0.
REQ-020 Channels not addressed by in_sel SHALL be unaffected by the upstream beat; a stalled channel SHALL NOT block upstream beats addressed to other channels.
REQ-021 ch_count[k] SHALL increment by 1 on every delivery on channel k, wrapping from 2^CW-1 to 0 without saturation or flag.
REQ-022 in_data and in_sel SHALL be ignored whenever in_valid=0.
REQ-023 Order SHALL be preserved per channel; no ordering guarantee is given across channels.

Reset
REQ-024 While rst=1 at a clock edge, every channel SHALL go to EMPTY, out_valid SHALL be 4'b0000, and ch_count SHALL be all zeros.
REQ-025 out_data SHALL reset to all zeros.
REQ-026 Reset asserted mid-operation SHALL discard all buffered beats; no delivery is counted in the reset cycle.
REQ-027 in_ready SHALL be 1 in the first cycle after reset, since all channels are EMPTY.

Structure
REQ-028 Package demux14_pkg SHALL hold NCH=4, SELW=2, and the channel state enum {EMPTY, FULL}.
REQ-029 The per-channel buffer, FSM, and counter SHALL be the sub-module demux14_chan, instantiated 4 times by generate.
REQ-030 The top SHALL contain only the select decode, the in_ready mux, and the port packing.

Verification
REQ-031 Reset, then send in_sel=2, in_data=8'hA5 with out_ready=4'b1111 -> out_valid=4'b0100 and out_data[2]=8'hA5 the next cycle; ch_count[2]=1 after that; all other channels stay 0.
REQ-032 Set out_ready[1]=0 and send two beats to channel 1 (8'h11, then 8'h22) -> first accepted, then in_ready=0 and out_data[1] holds 8'h11 stable; raising out_ready[1] delivers 8'h11, then 8'h22.
REQ-033 Stall channel 0 while it is FULL and send 8'h33 to channel 3 -> beat accepted, out_data[3]=8'h33 next cycle, and channel 0 is unchanged.
REQ-034 Keep channel 2 FULL with out_ready[2]=1 and stream 8'h01, 8'h02, 8'h03 back-to-back -> one beat per cycle, in_ready stays 1, and the data arrives in order.
REQ-035 Deliver 256 beats on channel 0 with CW=8 -> ch_count[0] wraps to 0.
REQ-036 Assert rst with channels 1 and 3 FULL -> out_valid=4'b0000 and ch_count all zero the next cycle, and neither buffered beat is ever delivered.
